// File: rtl/lbm_pkg.sv
// Shared widths, padding constant and FSM encoding for the Lbimatrix chaining front end.
package lbm_pkg;
  localparam int WORD_W    = 40;
  localparam int BLK_WORDS = 21;
  localparam int CHAIN_W   = WORD_W * BLK_WORDS;
  localparam int MSG_W     = 2 * CHAIN_W;
  localparam int IDX_W     = 5;

  localparam logic [WORD_W-1:0] PAD_WORD = 40'h80_0000_0000;

  typedef enum logic [2:0] {FILL, PAD, FIRE, WAIT, DONE} state_e;
endpackage

// File: rtl/lbm_blk_buf.sv
// 21-word data block buffer: one indexed write port, synchronous clear, flat read
// with word 0 in the most significant position.
module lbm_blk_buf
  import lbm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [WORD_W-1:0]  wdata,
  input  logic               clr,
  output logic [CHAIN_W-1:0] flat
);

  genvar gi;
  for (gi = 0; gi < BLK_WORDS; gi++) begin : g_word
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_q <= '0;
      end else if (clr) begin
        word_q <= '0;
      end else if (we && (widx == IDX_W'(gi))) begin
        word_q <= wdata;
      end
    end

    assign flat[(BLK_WORDS-1-gi)*WORD_W +: WORD_W] = word_q;
  end

endmodule

// File: rtl/lbm_chain_ctrl.sv
// Message packer and chaining controller feeding the Lbimatrix core.
// Define LBM_LENGTH_PAD_EN to place the message word count in word 20 of the final block.
module lbm_chain_ctrl
  import lbm_pkg::*;
#(
  parameter logic [CHAIN_W-1:0] IV = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  din,
  input  logic               din_valid,
  input  logic               din_last,
  output logic               din_ready,
  output logic [MSG_W-1:0]   msg_in,
  output logic               valid,
  input  logic [CHAIN_W-1:0] msg_out,
  input  logic               validout,
  output logic [CHAIN_W-1:0] digest,
  output logic               digest_valid
);

`ifdef LBM_LENGTH_PAD_EN
  localparam logic [IDX_W-1:0] PAD_MAX = 5'd18;
`else
  localparam logic [IDX_W-1:0] PAD_MAX = 5'd19;
`endif
  localparam logic [IDX_W-1:0] IDX_LAST = 5'(BLK_WORDS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CHAIN_W-1:0]   chain_q, chain_d;
  logic                 pad_pending_q, pad_pending_d;
  logic                 final_q, final_d;
  logic [MSG_W-1:0]     msg_in_q, msg_in_d;
  logic [CHAIN_W-1:0]   digest_q, digest_d;
`ifdef LBM_LENGTH_PAD_EN
  logic [WORD_W-1:0]    word_cnt_q, word_cnt_d;
`endif

  logic                 buf_we;
  logic [WORD_W-1:0]    buf_wdata;
  logic                 buf_clr;
  logic [CHAIN_W-1:0]   buf_flat;
  logic [CHAIN_W-1:0]   fire_blk;
  logic                 fill_ready;

  lbm_blk_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .widx  (idx_q),
    .wdata (buf_wdata),
    .clr   (buf_clr),
    .flat  (buf_flat)
  );

  always_comb begin
    fire_blk = buf_flat;
`ifdef LBM_LENGTH_PAD_EN
    if (final_q) fire_blk[WORD_W-1:0] = word_cnt_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      idx_q         <= '0;
      chain_q       <= IV;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      msg_in_q      <= '0;
      digest_q      <= '0;
`ifdef LBM_LENGTH_PAD_EN
      word_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chain_q       <= chain_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
      msg_in_q      <= msg_in_d;
      digest_q      <= digest_d;
`ifdef LBM_LENGTH_PAD_EN
      word_cnt_q    <= word_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chain_d       = chain_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    msg_in_d      = msg_in_q;
    digest_d      = digest_q;
`ifdef LBM_LENGTH_PAD_EN
    word_cnt_d    = word_cnt_q;
`endif
    buf_we        = 1'b0;
    buf_wdata     = din;
    buf_clr       = 1'b0;
    fill_ready    = 1'b0;

    case (state_q)
      FILL: begin
        fill_ready = 1'b1;
        if (din_valid) begin
          buf_we = 1'b1;
          idx_d  = idx_q + 5'd1;
`ifdef LBM_LENGTH_PAD_EN
          word_cnt_d = word_cnt_q + 40'd1;
`endif
          if (din_last) begin
            if (idx_q <= PAD_MAX) begin
              state_d = PAD;
            end else begin
              // No room for the pad word here; it opens an extra block.
              state_d       = FIRE;
              pad_pending_d = 1'b1;
            end
          end else if (idx_q == IDX_LAST) begin
            state_d = FIRE;
          end
        end
      end
      PAD: begin
        buf_we    = 1'b1;
        buf_wdata = PAD_WORD;
        final_d   = 1'b1;
        state_d   = FIRE;
      end
      FIRE: begin
        msg_in_d = {chain_q, fire_blk};
        state_d  = WAIT;
      end
      WAIT: begin
        if (validout) begin
          chain_d = msg_out;
          buf_clr = 1'b1;
          idx_d   = '0;
          if (final_q) begin
            state_d = DONE;
          end else if (pad_pending_q) begin
            pad_pending_d = 1'b0;
            state_d       = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        digest_d = chain_q;
        chain_d  = IV;
        final_d  = 1'b0;
`ifdef LBM_LENGTH_PAD_EN
        word_cnt_d = '0;
`endif
        state_d  = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Core input and digest are bypassed in their strobe cycle, then held in registers.
  assign din_ready    = fill_ready & ~rst;
  assign valid        = (state_q == FIRE);
  assign msg_in       = (state_q == FIRE) ? {chain_q, fire_blk} : msg_in_q;
  assign digest_valid = (state_q == DONE);
  assign digest       = (state_q == DONE) ? chain_q : digest_q;

endmodule

// File: tb/tb_lbm_chain_ctrl.sv
// Directed self-checking bench for lbm_chain_ctrl; the bench acts as the hash core.
`timescale 1ns/1ps
module tb_lbm_chain_ctrl;

  typedef logic [39:0] blk_t [21];

  localparam logic [39:0] PADW = 40'h80_0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [39:0]   din = '0;
  logic          din_valid = 1'b0;
  logic          din_last = 1'b0;
  logic          din_ready;
  logic [1679:0] msg_in;
  logic          valid;
  logic [839:0]  msg_out = '0;
  logic          validout = 1'b0;
  logic [839:0]  digest;
  logic          digest_valid;

  int vectors = 0;
  int miscompares = 0;
  int dv_cnt = 0;
  int st_cnt = 0;

  lbm_chain_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_last     (din_last),
    .din_ready    (din_ready),
    .msg_in       (msg_in),
    .valid        (valid),
    .msg_out      (msg_out),
    .validout     (validout),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (digest_valid) dv_cnt <= dv_cnt + 1;
    if (valid) st_cnt <= st_cnt + 1;
  end

  function automatic logic [839:0] mk_blk(input blk_t w);
    logic [839:0] b;
    for (int i = 0; i < 21; i++) b[(20-i)*40 +: 40] = w[i];
    return b;
  endfunction

  function automatic logic [839:0] res(input int k);
    return {21{40'hC0_DE00_0000 | 40'(k * 16'h0101)}};
  endfunction

  function automatic logic [39:0] len_word(input int n);
`ifdef LBM_LENGTH_PAD_EN
    return 40'(n);
`else
    return 40'(n) & 40'd0;
`endif
  endfunction

  function automatic blk_t zero_blk();
    blk_t w;
    for (int i = 0; i < 21; i++) w[i] = '0;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [39:0] w, input logic l);
    int n = 0;
    din = w; din_valid = 1'b1; din_last = l;
    while (!din_ready && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout word=%h ready stayed %b need 1", w, din_ready);
    end
    tick();
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic wait_fire(output logic [1679:0] m);
    int n = 0;
    while (!valid && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL fire_timeout valid=%b need 1", valid);
    end
    m = msg_in;
    $display("core start #%0d chain[39:0]=%h word0=%h", st_cnt + 1, m[879:840], m[839:800]);
  endtask

  task automatic core_respond(input logic [839:0] r);
    tick();
    validout = 1'b1; msg_out = r;
    tick();
    validout = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (din_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b need 0", din_ready); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b need 0", valid); end
    vectors++; if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL rst_dv got %b need 0", digest_valid); end
    vectors++; if (msg_in !== '0) begin miscompares++; $display("FAIL rst_msg_in not zero"); end
    vectors++; if (digest !== '0) begin miscompares++; $display("FAIL rst_digest not zero"); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if (din_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %b need 1", din_ready); end
    tick();
  endtask

  task automatic test_full_block();
    blk_t w;
    logic [1679:0] m;
    int d0 = dv_cnt, s0 = st_cnt;
    for (int i = 1; i <= 20; i++) send_word(40'(i), 1'b0);
    send_word(40'd21, 1'b1);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL full_latency valid=%b need 1", valid); end
    vectors++; if (din_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_fire got %b need 0", din_ready); end
    m = msg_in;
    for (int i = 0; i < 21; i++) w[i] = 40'(i + 1);
    vectors++; if (m[839:0] !== mk_blk(w)) begin miscompares++; $display("FAIL full_blk1 got %h need %h", m[839:0], mk_blk(w)); end
    vectors++; if (m[1679:840] !== '0) begin miscompares++; $display("FAIL full_chain1 got %h need IV", m[1679:840]); end
    core_respond(res(1));
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL full_pad_cycle valid=%b need 0", valid); end
    wait_fire(m);
    w = zero_blk(); w[0] = PADW; w[20] = len_word(21);
    vectors++; if (m[839:0] !== mk_blk(w)) begin miscompares++; $display("FAIL full_blk2 got %h need %h", m[839:0], mk_blk(w)); end
    vectors++; if (m[1679:840] !== res(1)) begin miscompares++; $display("FAIL full_chain2 got %h need %h", m[1679:840], res(1)); end
    core_respond(res(2));
    vectors++; if (digest_valid !== 1'b1) begin miscompares++; $display("FAIL full_dv got %b need 1", digest_valid); end
    vectors++; if (digest !== res(2)) begin miscompares++; $display("FAIL full_digest got %h need %h", digest, res(2)); end
    tick();
    vectors++; if (digest !== res(2)) begin miscompares++; $display("FAIL full_digest_hold got %h need %h", digest, res(2)); end
    vectors++; if (dv_cnt - d0 != 1) begin miscompares++; $display("FAIL full_dv_pulses got %0d need 1", dv_cnt - d0); end
    vectors++; if (st_cnt - s0 != 2) begin miscompares++; $display("FAIL full_starts got %0d need 2", st_cnt - s0); end
  endtask

  task automatic test_short();
    blk_t w;
    send_word(40'h11_2233_4455, 1'b0);
    send_word(40'h66_7788_99AA, 1'b0);
    send_word(40'hBB_CCDD_EEFF, 1'b1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL short_early_valid got %b need 0", valid); end
    tick();
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL short_latency valid=%b need 1", valid); end
    w = zero_blk();
    w[0] = 40'h11_2233_4455; w[1] = 40'h66_7788_99AA; w[2] = 40'hBB_CCDD_EEFF; w[3] = PADW; w[20] = len_word(3);
    vectors++; if (msg_in[839:0] !== mk_blk(w)) begin miscompares++; $display("FAIL short_blk got %h need %h", msg_in[839:0], mk_blk(w)); end
    vectors++; if (msg_in[1679:840] !== '0) begin miscompares++; $display("FAIL short_chain got %h need IV", msg_in[1679:840]); end
    core_respond(res(3));
    vectors++; if (digest_valid !== 1'b1 || digest !== res(3)) begin miscompares++; $display("FAIL short_digest dv=%b got %h need %h", digest_valid, digest, res(3)); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1679:0] cap [3];
    blk_t w;
    fork
      begin
        for (int i = 1; i <= 42; i++) begin
          send_word(40'h100 + 40'(i), i == 42);
          tick();
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_fire(cap[k]);
          tick();
          for (int j = 0; j < 3; j++) begin
            vectors++; if (din_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_wait blk=%0d got %b need 0", k, din_ready); end
            if (j < 2) tick();
          end
          validout = 1'b1; msg_out = res(10 + k);
          tick();
          validout = 1'b0;
          if (k == 2) begin
            vectors++; if (digest_valid !== 1'b1 || digest !== res(12)) begin miscompares++; $display("FAIL b2b_digest dv=%b got %h need %h", digest_valid, digest, res(12)); end
          end
        end
      end
    join
    for (int i = 0; i < 21; i++) w[i] = 40'h101 + 40'(i);
    vectors++; if (cap[0] !== {840'd0, mk_blk(w)}) begin miscompares++; $display("FAIL b2b_blk0 got %h need %h", cap[0][839:0], mk_blk(w)); end
    for (int i = 0; i < 21; i++) w[i] = 40'h116 + 40'(i);
    vectors++; if (cap[1][839:0] !== mk_blk(w)) begin miscompares++; $display("FAIL b2b_blk1 got %h need %h", cap[1][839:0], mk_blk(w)); end
    vectors++; if (cap[1][1679:840] !== res(10)) begin miscompares++; $display("FAIL b2b_chain1 got %h need %h", cap[1][1679:840], res(10)); end
    w = zero_blk(); w[0] = PADW; w[20] = len_word(42);
    vectors++; if (cap[2] !== {res(11), mk_blk(w)}) begin miscompares++; $display("FAIL b2b_blk2 got %h need %h", cap[2][839:0], mk_blk(w)); end
    tick();
  endtask

  task automatic test_spurious();
    logic [1679:0] m;
    blk_t w;
    validout = 1'b1; msg_out = {21{40'hDE_ADBE_EF00}};
    tick();
    vectors++; if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL spur_dv got %b need 0", digest_valid); end
    tick();
    validout = 1'b0;
    vectors++; if (digest !== res(12)) begin miscompares++; $display("FAIL spur_digest got %h need %h", digest, res(12)); end
    send_word(40'h00_0000_005A, 1'b1);
    wait_fire(m);
    w = zero_blk(); w[0] = 40'h5A; w[1] = PADW; w[20] = len_word(1);
    vectors++; if (m !== {840'd0, mk_blk(w)}) begin miscompares++; $display("FAIL spur_chain got %h need IV", m[1679:840]); end
    core_respond(res(13));
    vectors++; if (digest !== res(13)) begin miscompares++; $display("FAIL spur_final_digest got %h need %h", digest, res(13)); end
    tick();
  endtask

  task automatic test_reset_wait();
    logic [1679:0] m;
    blk_t w;
    int d0;
    send_word(40'hD, 1'b0);
    send_word(40'hE, 1'b0);
    send_word(40'hF, 1'b1);
    wait_fire(m);
    tick();
    rst = 1'b1;
    #1;
    vectors++; if (din_ready !== 1'b0 || valid !== 1'b0) begin miscompares++; $display("FAIL rw_outputs ready=%b valid=%b need 0 0", din_ready, valid); end
    vectors++; if (msg_in !== '0 || digest !== '0) begin miscompares++; $display("FAIL rw_regs msg_in/digest not cleared"); end
    tick();
    rst = 1'b0;
    d0 = dv_cnt;
    validout = 1'b1; msg_out = res(14);
    tick();
    validout = 1'b0;
    tick();
    vectors++; if (dv_cnt != d0 || digest !== '0) begin miscompares++; $display("FAIL rw_late_validout pulses=%0d need 0", dv_cnt - d0); end
    send_word(40'h77, 1'b1);
    wait_fire(m);
    w = zero_blk(); w[0] = 40'h77; w[1] = PADW; w[20] = len_word(1);
    vectors++; if (m !== {840'd0, mk_blk(w)}) begin miscompares++; $display("FAIL rw_restart got %h need %h", m[839:0], mk_blk(w)); end
    core_respond(res(15));
    vectors++; if (digest_valid !== 1'b1 || digest !== res(15)) begin miscompares++; $display("FAIL rw_digest dv=%b got %h", digest_valid, digest); end
    tick();
  endtask

`ifdef LBM_LENGTH_PAD_EN
  task automatic test_length();
    logic [1679:0] m;
    blk_t w;
    for (int i = 1; i <= 20; i++) send_word(40'(i), i == 20);
    wait_fire(m);
    w = zero_blk();
    for (int i = 0; i < 20; i++) w[i] = 40'(i + 1);
    vectors++; if (m !== {840'd0, mk_blk(w)}) begin miscompares++; $display("FAIL len_blk1 got %h need %h", m[839:0], mk_blk(w)); end
    core_respond(res(16));
    wait_fire(m);
    w = zero_blk(); w[0] = PADW; w[20] = 40'd20;
    vectors++; if (m !== {res(16), mk_blk(w)}) begin miscompares++; $display("FAIL len_blk2 got %h need %h", m[839:0], mk_blk(w)); end
    core_respond(res(17));
    vectors++; if (digest !== res(17)) begin miscompares++; $display("FAIL len_digest got %h need %h", digest, res(17)); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_full_block();
    test_short();
    test_back_to_back();
    test_spurious();
    test_reset_wait();
`ifdef LBM_LENGTH_PAD_EN
    test_length();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
